// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state codes,
// handshake level names and the EX-stage aluop codes that select it.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] div_state_bus_t;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider request/response bundle. EX is the master, the divider
// the slave.
interface div_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, sign fixup on the final edge, result held until EX drops start.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             signed_r, sign1, sign2;

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] op1_abs, op2_abs, quo, rem, quo_fix, rem_fix;

  // Extra top bit makes the borrow of the trial subtract explicit.
  assign diff    = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

  assign op1_abs = (bus.signed_div_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  assign quo     = dividend[WIDTH-1:0];
  assign rem     = dividend[2*WIDTH:WIDTH+1];
  // Remainder follows the dividend's sign; quotient is negative on sign mismatch.
  assign quo_fix = (signed_r & (sign1 ^ sign2)) ? -quo : quo;
  assign rem_fix = (signed_r & sign1) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= '0;
      dividend     <= '0;
      divisor      <= '0;
      signed_r     <= 1'b0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          bus.ready_o  <= DivResultNotReady;
          bus.result_o <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            signed_r <= bus.signed_div_i;
            sign1    <= bus.opdata1_i[WIDTH-1];
            sign2    <= bus.opdata2_i[WIDTH-1];
            if (bus.opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              dividend <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
              divisor  <= op2_abs;
              cnt      <= '0;
              state    <= DivOn;
            end
          end
        end
        DivByZero: begin
          dividend <= '0;
          state    <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state       <= DivFree;
            cnt         <= '0;
            bus.ready_o <= DivResultNotReady;
          end else if (cnt != CNT_LAST) begin
            if (diff[WIDTH])
              dividend <= dividend << 1;
            else
              dividend <= {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            bus.result_o <= {rem_fix, quo_fix};
            bus.ready_o  <= DivResultReady;
            state        <= DivEnd;
            cnt          <= '0;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            state        <= DivFree;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
          end else begin
            bus.ready_o <= DivResultReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, reset mid-divide and operand changes while busy.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide with start held, measure edges from the start-sampling
  // edge to ready, check the result, optionally poke the inputs while busy
  // or in END, then release start and check the return to idle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                         input bit scramble, input bit annul_in_end);
    int n;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
    n = 0;
    if (scramble) begin
      bus.signed_div_i = ~sgn;
      bus.opdata1_i    = 32'hDEAD_BEEF;
      bus.opdata2_i    = 32'h0000_0003;
    end
    do begin
      tick();
      n++;
    end while (!bus.ready_o && n < 40);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, bus.result_o, exp);
    if (annul_in_end) begin
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0;
      check({tag, " end ignores annul ready"}, 64'(bus.ready_o), 64'd1);
      check({tag, " end ignores annul result"}, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    tick();
    check({tag, " idle ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " idle result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    check("reset state", 64'(dut.state), 64'(DivFree));
    rst = 1'b0;
    tick();

    run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, 1'b1);
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, 1'b0);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1'b0, 1'b0);
    run_div("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 1'b0, 1'b0);
    run_div("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0, 1'b0);
    run_div("s div0", 1'b1, 32'h1234, 32'd0, 64'd0, 2, 1'b0, 1'b0);
    run_div("u div0", 1'b0, 32'h1234, 32'd0, 64'd0, 2, 1'b0, 1'b0);

    // Annul after ten iterations.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("annul cnt", 64'(dut.cnt), 64'd10);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    check("annul state", 64'(dut.state), 64'(DivFree));
    check("annul ready", 64'(bus.ready_o), 64'd0);
    tick();
    check("annul ready held low", 64'(bus.ready_o), 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0, 1'b0);

    // Reset after twenty iterations.
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_FFF9;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("rst cnt before", 64'(dut.cnt), 64'd20);
    rst = 1'b1;
    tick();
    check("rst mid ready", 64'(bus.ready_o), 64'd0);
    check("rst mid result", bus.result_o, 64'd0);
    check("rst mid state", 64'(dut.state), 64'(DivFree));
    check("rst mid cnt", 64'(dut.cnt), 64'd0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    tick();

    run_div("scrambled u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1, 1'b0);
    run_div("scrambled s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider fed by the EX stage for DIV/DIVU.
- EX supplies the operands and holds `start_i` until `ready_o` rises.
- The result is returned as `{remainder, quotient}`; EX routes it to HI/LO through its existing whilo path.
- EX stalls the pipeline while the divide is in flight; stall generation lives in EX, not here.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until the result is consumed.
- annul_i  in  1  abort the in-flight divide (branch/exception flush).
- result_o  out  2*WIDTH  `{remainder[63:32], quotient[31:0]}`.
- ready_o  out  1  result valid.

Behaviour:
- All state and outputs are registered.
- On rst: state = FREE, cnt = 0, result_o = 0, ready_o = 0. Reset mid-divide discards all work.
- States: FREE, BYZERO, ON, END.
- FREE, at an edge with start_i=1 and annul_i=0:
  - Capture signed_div_i, sign1 = op1[31], sign2 = op2[31].
  - a = (signed & op1[31]) ? -op1 : op1; b likewise from op2.
  - If op2 == 0: go to BYZERO.
  - Else: dividend(65b) = {32'b0, a, 1'b0}, divisor = b, cnt = 0, go to ON.
  - Inputs are ignored in every other case.
- FREE otherwise: ready_o = 0, result_o = 0.
- BYZERO: next edge, dividend = 0, go to END. Result is 0; ready_o rises 2 edges after the start edge.
- ON with annul_i=1: go to FREE, cnt = 0, ready_o = 0. Annul takes priority over iteration and fixup.
- ON with cnt < 32, each edge:
  - diff = dividend[63:32] - divisor, computed 33b.
  - If diff[32] (negative): dividend <<= 1.
  - Else: dividend = {diff[31:0], dividend[31:0], 1'b1}.
  - cnt++.
- ON with cnt == 32, fixup edge:
  - q = dividend[31:0]; r = dividend[64:33].
  - Negate q if signed & (sign1 ^ sign2).
  - Negate r if signed & sign1; remainder takes the dividend's sign.
  - result_o = {r, q}, ready_o = 1, go to END, cnt = 0.
- END: hold result_o and ready_o while start_i=1.
  - When start_i=0: go to FREE, ready_o = 0, result_o = 0 on that edge.
  - annul_i is ignored in END.
- Latency: ready_o rises at the 33rd edge after the start-sampling edge. No back-to-back start without passing through FREE.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives q = 0x80000000, r = 0 (wraps, no trap).
- Widths: all negation is two's complement in WIDTH bits. The iteration subtract is WIDTH+1 bits, so the borrow is explicit.

Decomposition:
- Add to the shared define header:
  - State codes `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2b), with bus macro `DivStateBus`.
  - `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`.
  - `EXE_DIV_OP`/`EXE_DIVU_OP` aluop codes.
- Single module; no sub-module is warranted. The iteration step is a few lines of combinational logic inside it.

Test Plan:
- Unsigned 100/7, start held → ready_o high at edge 33 after start; result_o = {32'd2, 32'd14}; after start_i drops, next edge ready_o = 0 and result_o = 0.
- Signed -7/2 (0xFFFFFFF9 / 2) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Unsigned 0xFFFFFFF9/2 → {0x1, 0x7FFFFFFC}. Signed 0x80000000/0xFFFFFFFF → {0x0, 0x80000000}.
- Divisor 0 (signed and unsigned, op1 = 0x1234) → ready_o at edge 2 after start; result_o = 0.
- annul_i pulsed at cnt=10 → next edge state FREE, ready_o stays 0. A new start of 9/3 then completes with {0, 3} after a full 33 edges.
- rst asserted at cnt=20 → next edge all outputs 0, state FREE. Operands changed mid-divide (without rst) do not alter the result, which still matches the captured operands.
